// File: rtl/eight_bit_pkg.sv
// eight_bit_pkg: opcodes, register codes, field positions and state/strobe types shared by the 8-bit processor
package eight_bit_pkg;
  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_MUL = 4'h2;
  localparam logic [3:0] OP_DIV = 4'h3;
  localparam logic [3:0] OP_SHL = 4'h4;
  localparam logic [3:0] OP_SHR = 4'h5;
  localparam logic [3:0] OP_SQA = 4'h6;
  localparam logic [3:0] OP_SQB = 4'h7;
  localparam logic [3:0] OP_LDL = 4'h8;
  localparam logic [3:0] OP_LDA = 4'h9;
  localparam logic [3:0] OP_LDB = 4'hA;
  localparam logic [3:0] OP_OUT = 4'hB;
  localparam logic [1:0] REG1 = 2'd0;
  localparam logic [1:0] REG2 = 2'd1;
  localparam logic [1:0] REG3 = 2'd2;
  localparam logic [1:0] REG4 = 2'd3;
  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RA_HI = 3;
  localparam int RA_LO = 2;
  localparam int RB_HI = 1;
  localparam int RB_LO = 0;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT_ALU, S_HALT} state_t;
  typedef struct packed {
    logic alu_go;
    logic load_acc;
    logic load_a;
    logic load_b;
    logic out_en;
  } strobes_t;
endpackage

// File: rtl/eight_bit_sequencer_if.sv
// eight_bit_sequencer_if: ROM fetch bus plus ALU/datapath strobes between sequencer (master) and the rest of the core
interface eight_bit_sequencer_if;
  logic [1:0] prog;
  logic [7:0] address;
  logic [7:0] instruction;
  logic [3:0] alu_op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic       alu_go;
  logic       alu_done;
  logic       load_a;
  logic       load_b;
  logic       load_acc;
  logic       out_en;
  modport master (
    output prog, address, alu_op, ra, rb, alu_go, load_a, load_b, load_acc, out_en,
    input  instruction, alu_done
  );
  modport slave (
    input  prog, address, alu_op, ra, rb, alu_go, load_a, load_b, load_acc, out_en,
    output instruction, alu_done
  );
endinterface

// File: rtl/eight_bit_decoder.sv
// eight_bit_decoder: maps an opcode to its strobe vector and class flags; reserved or unknown opcodes decode as illegal NOPs
module eight_bit_decoder
  import eight_bit_pkg::*;
(
  input  logic [3:0] opcode,
  output strobes_t   strb,
  output logic       is_alu,
  output logic       is_out,
  output logic       is_illegal
);
  always_comb begin
    strb = '0;
    is_alu = 1'b0;
    is_out = 1'b0;
    is_illegal = 1'b0;
    case (opcode) inside
      [OP_ADD:OP_SQB]: begin strb.alu_go = 1'b1; is_alu = 1'b1; end
      OP_LDL: strb.load_acc = 1'b1;
      OP_LDA: strb.load_a = 1'b1;
      OP_LDB: strb.load_b = 1'b1;
      OP_OUT: begin strb.out_en = 1'b1; is_out = 1'b1; end
      default: is_illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/eight_bit_sequencer.sv
// eight_bit_sequencer: fetch/decode/execute controller; SEQ_SINGLE_STEP_EN adds step/at_break to hold DECODE until stepped
module eight_bit_sequencer
  import eight_bit_pkg::*;
#(
  parameter int         ALU_TIMEOUT = 16,
  parameter logic [7:0] LAST_ADDR   = 8'hFF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   prog_sel,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic                         step,
  output logic                         at_break,
`endif
  eight_bit_sequencer_if.master        bus,
  output logic                         busy,
  output logic                         halted,
  output logic                         error,
  output logic                         illegal_seen
);
  localparam int CW = $clog2(ALU_TIMEOUT + 1);
  state_t         state, state_nx;
  logic [1:0]     prog;
  logic [7:0]     address;
  logic [7:0]     ir;
  logic [CW-1:0]  cnt;
  strobes_t       dec_strb, strb;
  logic           is_alu, is_out, is_illegal;
  logic           accept, adv, err_set, at_last;
  eight_bit_decoder u_dec (
    .opcode     (ir[OPC_HI:OPC_LO]),
    .strb       (dec_strb),
    .is_alu     (is_alu),
    .is_out     (is_out),
    .is_illegal (is_illegal)
  );
  assign at_last = address == LAST_ADDR;
  always_comb begin
    state_nx = state;
    accept = 1'b0;
    adv = 1'b0;
    err_set = 1'b0;
    strb = '0;
    case (state)
      S_IDLE, S_HALT: if (start) begin state_nx = S_FETCH; accept = 1'b1; end
      S_FETCH: state_nx = S_DECODE;
`ifdef SEQ_SINGLE_STEP_EN
      S_DECODE: state_nx = step ? S_EXEC : S_DECODE;
`else
      S_DECODE: state_nx = S_EXEC;
`endif
      S_EXEC: begin
        strb = dec_strb;
        state_nx = is_alu ? S_WAIT_ALU : is_out ? S_HALT : state;
        adv = !is_alu && !is_out;
      end
      S_WAIT_ALU: begin
        adv = bus.alu_done;
        if (!bus.alu_done && cnt == CW'(ALU_TIMEOUT - 1)) begin err_set = 1'b1; state_nx = S_HALT; end
      end
      default: state_nx = S_IDLE;
    endcase
    // PC advance: running past the last fetchable address is an error, never a wrap
    if (adv) begin
      state_nx = at_last ? S_HALT : S_FETCH;
      err_set = at_last;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      prog <= '0;
      address <= '0;
      ir <= '0;
      cnt <= '0;
      error <= 1'b0;
      illegal_seen <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state == S_WAIT_ALU ? cnt + 1'b1 : '0;
      if (state == S_FETCH) ir <= bus.instruction;
      if (adv && !at_last) address <= address + 8'd1;
      if (err_set) error <= 1'b1;
      if (state == S_EXEC && is_illegal) illegal_seen <= 1'b1;
      if (accept) begin
        prog <= prog_sel;
        address <= '0;
        error <= 1'b0;
        illegal_seen <= 1'b0;
      end
    end
  end
  assign bus.prog = prog;
  assign bus.address = address;
  assign bus.alu_op = ir[OPC_HI:OPC_LO];
  assign bus.ra = ir[RA_HI:RA_LO];
  assign bus.rb = ir[RB_HI:RB_LO];
  assign bus.alu_go = strb.alu_go;
  assign bus.load_acc = strb.load_acc;
  assign bus.load_a = strb.load_a;
  assign bus.load_b = strb.load_b;
  assign bus.out_en = strb.out_en;
  assign busy = state != S_IDLE && state != S_HALT;
  assign halted = state == S_HALT;
`ifdef SEQ_SINGLE_STEP_EN
  assign at_break = state == S_DECODE && !step;
`endif
endmodule

// File: tb/tb_eight_bit_sequencer.sv
// tb_eight_bit_sequencer: random programs and ALU latencies checked against an instruction-level timing model
module tb_eight_bit_sequencer;
  localparam int TO = 16;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] prog_sel = 2'd0;
  logic       busy, halted, error, illegal_seen;
  logic [4:0] stb;
  logic [7:0] rom [4][256];
  int         lat [64];
  logic [63:0] exp_q[$];
  logic [63:0] got_q[$];
  int         cyc, done_at, nalu, poke_at;
  logic [1:0] poke_sel;
  int         checks = 0;
  int         errors = 0;
  logic       exp_err, exp_ill;
  logic [7:0] exp_addr;
  int         exp_end;
  eight_bit_sequencer_if bif();
`ifdef SEQ_SINGLE_STEP_EN
  logic step = 1'b1;
  logic at_break;
`endif
  eight_bit_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .prog_sel     (prog_sel),
`ifdef SEQ_SINGLE_STEP_EN
    .step         (step),
    .at_break     (at_break),
`endif
    .bus          (bif.master),
    .busy         (busy),
    .halted       (halted),
    .error        (error),
    .illegal_seen (illegal_seen)
  );
  always #5 clk = ~clk;
  assign bif.instruction = rom[bif.prog][bif.address];
  assign stb = {bif.alu_go, bif.load_acc, bif.load_a, bif.load_b, bif.out_en};
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] ev(input int c, input logic [4:0] k, input logic [7:0] a, input logic [7:0] i);
    return {27'd0, c[15:0], k, a, i};
  endfunction
  // Instruction-level model: FETCH/DECODE/EXEC per instruction, ALU ops add their latency
  task automatic model(input int p);
    int pc = 0;
    int c = 1;
    int k = 0;
    int ex, l, op;
    logic [7:0] ins;
    exp_q.delete();
    exp_err = 1'b0;
    exp_ill = 1'b0;
    forever begin
      ins = rom[p][pc];
      op = int'(ins[7:4]);
      ex = c + 2;
      if (op == 11) begin
        exp_q.push_back(ev(ex, 5'b00001, 8'(pc), ins));
        exp_end = ex + 1;
        break;
      end
      if (op < 8) begin
        exp_q.push_back(ev(ex, 5'b10000, 8'(pc), ins));
        l = lat[k];
        k++;
        if (l > TO) begin
          exp_err = 1'b1;
          exp_end = ex + TO + 1;
          break;
        end
        c = ex + l + 1;
      end else begin
        if (op == 8) exp_q.push_back(ev(ex, 5'b01000, 8'(pc), ins));
        else if (op == 9) exp_q.push_back(ev(ex, 5'b00100, 8'(pc), ins));
        else if (op == 10) exp_q.push_back(ev(ex, 5'b00010, 8'(pc), ins));
        else exp_ill = 1'b1;
        c = ex + 1;
      end
      if (pc == 255) begin
        exp_err = 1'b1;
        exp_end = c;
        break;
      end
      pc++;
    end
    exp_addr = 8'(pc);
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bif.alu_done = cyc == done_at;
    start = cyc == poke_at;
    if (start) prog_sel = poke_sel;
    @(negedge clk);
    if (stb != 5'b0) got_q.push_back(ev(cyc, stb, bif.address, {bif.alu_op, bif.ra, bif.rb}));
    if (bif.alu_go) begin
      done_at = cyc + lat[nalu];
      nalu++;
    end
  endtask
  task automatic begin_prog(input int p, input int pk);
    got_q.delete();
    nalu = 0;
    done_at = -1;
    poke_at = pk;
    poke_sel = 2'(p) ^ 2'b11;
    cyc = 0;
    prog_sel = 2'(p);
    start = 1'b1;
    tick();
  endtask
  task automatic run(input int p, input int pk);
    model(p);
    begin_prog(p, pk);
    check("clr_err", 64'(error), 64'd0);
    check("clr_ill", 64'(illegal_seen), 64'd0);
    check("busy_run", 64'(busy), 64'd1);
    while (!halted && cyc < 3000) tick();
    check("halt_cyc", 64'(cyc), 64'(exp_end));
    check("n_events", 64'(got_q.size()), 64'(exp_q.size()));
    foreach (exp_q[i]) check("event", i < got_q.size() ? got_q[i] : 64'hDEAD, exp_q[i]);
    check("error", 64'(error), 64'(exp_err));
    check("illegal", 64'(illegal_seen), 64'(exp_ill));
    check("address", 64'(bif.address), 64'(exp_addr));
    check("prog", 64'(bif.prog), 64'(p));
    check("busy_end", 64'(busy), 64'd0);
  endtask
  task automatic set_lat(input int lo, input int hi);
    foreach (lat[i]) lat[i] = $urandom_range(hi, lo);
  endtask
  task automatic chk_reset(input string tag);
    check(tag, {bif.prog, bif.address, bif.alu_op, bif.ra, bif.rb, stb, busy, halted, error, illegal_seen}, 64'd0);
  endtask
  initial begin
    bif.alu_done = 1'b0;
    foreach (rom[p, a]) rom[p][a] = 8'hF0;
    rom[1][0] = {4'h9, 4'($urandom)};
    rom[1][1] = {4'hB, 4'($urandom)};
    rom[2][0] = {4'h9, 4'($urandom)};
    rom[2][1] = {4'hA, 4'($urandom)};
    rom[2][2] = {4'h2, 4'($urandom)};
    rom[2][3] = {4'h4, 4'($urandom)};
    rom[2][4] = {4'hB, 4'($urandom)};
    for (int a = 0; a < 256; a++) rom[3][a] = {4'h8, 4'($urandom)};
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    set_lat(1, 4);
    run(1, -1);
    set_lat(2, 2);
    run(2, -1);
    for (int it = 0; it < 6; it++) begin
      for (int a = 0; a < 6; a++) rom[0][a] = {4'($urandom_range(10, 0)), 4'($urandom)};
      rom[0][6] = {4'($urandom_range(15, 12)), 4'($urandom)};
      rom[0][7] = {4'hB, 4'($urandom)};
      set_lat(1, 16);
      run(0, it[0] ? int'($urandom_range(6, 2)) : -1);
    end
    set_lat(16, 16);
    run(2, 4);
    set_lat(17, 17);
    run(2, -1);
    set_lat(1, 3);
    run(1, -1);
    run(3, -1);
    set_lat(30, 30);
    begin_prog(2, -1);
    repeat (10) tick();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    repeat (10) tick();
    check("post_rst_events", 64'(got_q.size()), 64'd0);
    chk_reset("post_rst_idle");
    set_lat(1, 5);
    run(1, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/eight_bit_sequencer.md
Name: eight_bit_sequencer

Overview:
- Fetch/decode/execute controller for the 8-bit processor.
- Sits directly upstream of the program ROM: drives `prog` and `address`, then latches the returned 8-bit instruction.
- Decodes the instruction fields: opcode[7:4], ra[3:2], rb[1:0].
- Issues one-hot load/ALU/output strobes to the datapath and handshakes with the ALU for multi-cycle ops.

Parameters:
- ALU_TIMEOUT, 16: maximum cycles to wait for `alu_done` before flagging an error and halting.
- LAST_ADDR, 8'hFF: highest fetchable address; running past it without OUT halts with an error.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; begins the program selected by `prog_sel`; ignored unless in IDLE or HALT
- prog_sel  in  2  program select, sampled on `start`
- prog  out  2  registered program select driven to the ROM
- address  out  8  program counter driven to the ROM
- instruction  in  8  ROM data; combinational with respect to `address`/`prog`
- alu_op  out  4  opcode forwarded to the ALU (0000–0111), held through WAIT_ALU
- ra  out  2  first register field of the latched instruction
- rb  out  2  second register field of the latched instruction
- alu_go  out  1  one-cycle ALU start strobe
- alu_done  in  1  ALU completion; level, sampled only in WAIT_ALU
- load_a  out  1  one-cycle strobe: load operand A (lda)
- load_b  out  1  one-cycle strobe: load operand B (ldb)
- load_acc  out  1  one-cycle strobe: write ALU result to register `ra` (ldl)
- out_en  out  1  one-cycle strobe: present register `ra` on the output port (out)
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- error  out  1  sticky; cleared by reset or by an accepted `start`
- illegal_seen  out  1  sticky; set when a reserved opcode executes

Behaviour:
- Reset values:
  - State IDLE.
  - `prog`=0, `address`=0, instruction register=0.
  - All strobes 0; `busy`, `halted`, `error`, `illegal_seen` = 0.
- State machine: IDLE, FETCH, DECODE, EXEC, WAIT_ALU, HALT.
- IDLE/HALT + `start`:
  - `prog`←`prog_sel`, `address`←0.
  - `error` and `illegal_seen` cleared.
  - Next state FETCH.
- FETCH (1 cycle):
  - `address` is stable for the whole cycle.
  - Instruction register latches `instruction` at the end of the cycle.
  - Next state DECODE.
- DECODE (1 cycle):
  - `ra`, `rb` and `alu_op` update from the latched instruction.
  - No strobes are asserted.
  - Next state EXEC.
- EXEC (exactly one strobe pulses, for one cycle):
  - 0000–0111 (add, sub, mul, div, shl, shr, sqa, sqb): `alu_go`=1, next state WAIT_ALU.
  - 1000 ldl: `load_acc`. 1001 lda: `load_a`. 1010 ldb: `load_b`. All three advance the PC.
  - 1011 out: `out_en`, next state HALT. `address` holds the OUT address.
  - 1100–1111, and any X/Z in simulation: treated as NOP. Sets `illegal_seen`, advances the PC.
- WAIT_ALU:
  - On `alu_done`=1: advance the PC.
  - Otherwise count cycles. After ALU_TIMEOUT cycles without `alu_done`: set `error`, go to HALT.
  - `alu_done` already high in the first WAIT_ALU cycle is accepted (minimum ALU op = 3 cycles of sequencer time after FETCH).
- Advance the PC:
  - If `address`==LAST_ADDR: set `error`, go to HALT (no wrap).
  - Else `address`+1, go to FETCH.
- Instruction throughput: a non-ALU instruction takes 3 cycles (FETCH, DECODE, EXEC).
- `start` while busy: ignored, no side effects.
- Asynchronous reset mid-instruction: immediate return to reset values; pending strobes are dropped.
- Strobes are mutually exclusive in every cycle.

Optional Feature:
- Macro: SEQ_SINGLE_STEP_EN.
- Enabled:
  - Adds input port `step` (1 bit).
  - DECODE holds until `step` is high for a cycle, then goes to EXEC.
  - Adds output `at_break`, high while DECODE is held.
- Disabled: the `step` and `at_break` ports do not exist; DECODE is always one cycle.

Decomposition:
- Shared package `eight_bit_pkg` holds:
  - Opcode localparams OP_ADD…OP_OUT (0000–1011).
  - Register codes REG1–REG4.
  - Field slice positions.
  - The state enum typedef.
- The ROM and the sequencer both import it.
- One sub-module: `eight_bit_decoder`, combinational. Maps opcode to strobe vector plus is_alu/is_out/is_illegal.

Test Plan:
- Program 1 (lda; out), `start` with `prog_sel`=01:
  - `load_a` pulses at cycle 3, `address` 0→1.
  - `out_en` pulses at cycle 6, then `halted`=1 with `address`=1.
  - `error`=0.
- Program 2 (lda, ldb, mul, shl, out), ALU returns `alu_done` 2 cycles after each `alu_go`:
  - Two `alu_go` pulses with `alu_op` 0010 then 0100.
  - `out_en` at `address`=4, then HALT.
- Program 0 with empty address 6 (X/Z):
  - NOP at address 6 sets `illegal_seen`=1.
  - Execution continues; `out_en` fires at address 7.
- `alu_done` held low:
  - `error` rises exactly ALU_TIMEOUT cycles after `alu_go`; `halted`=1.
  - A following `start` clears `error`.
- `rst_n` pulsed low during WAIT_ALU:
  - Outputs return to reset values asynchronously.
  - No strobe fires after release until the next `start`.
- ROM stub returning 1000 everywhere, LAST_ADDR=3:
  - 4 `load_acc` pulses, then `error`=1 and `halted` with `address`=3.
- `start` pulse while busy:
  - Ignored; `prog` unchanged and the `address` sequence is unchanged.
